mem_controller: RTL

Responder-side memory controller for the data and program memory valid/ready interfaces driven by each core's LSUs and fetcher. It arbitrates `NUM_CONSUMERS` request ports onto `NUM_CHANNELS` external memory channels and relays each response back to the consumer that issued it. It implements the consumer protocol exactly: valid is held until ready, and ready is held until valid drops. One instance serves data memory; a read-only instance, with `WRITE_ENABLE=0`, serves program memory.

---
 rtl/mem_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_controller.sv
// Memory controller: arbitrates NUM_CONSUMERS valid/ready request ports onto NUM_CHANNELS memory channels.
// Latency: grant registered 1 cycle after consumer valid; consumer ready 1 cycle after memory ready (2-cycle minimum round trip).
// Backpressure: a channel stays owned until memory answers and the consumer drops valid; unserved consumers simply wait.
//
// Ports:
//   clk, reset                     - single clock, synchronous active-high reset
//   consumer_read_*  / consumer_write_*  - per-consumer request (valid/address/data) and response (ready/data)
//   mem_read_*       / mem_write_*       - per-channel external memory request and acknowledge
module mem_controller #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
   input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
   input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
   output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
   input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

   localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      READ_WAITING,
      WRITE_WAITING,
      READ_RELAYING,
      WRITE_RELAYING
   } state_t;

   state_t                                    r_state [NUM_CHANNELS];
   logic [CW-1:0]                             r_cur   [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0]                  r_claimed;

   logic [NUM_CHANNELS-1:0]                   r_mem_read_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    r_mem_read_address;
   logic [NUM_CHANNELS-1:0]                   r_mem_write_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    r_mem_write_address;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    r_mem_write_data;
   logic [NUM_CONSUMERS-1:0]                  r_cons_read_ready;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   r_cons_read_data;
   logic [NUM_CONSUMERS-1:0]                  r_cons_write_ready;

   state_t                                    w_state_nxt [NUM_CHANNELS];
   logic [CW-1:0]                             w_gnt_idx   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]                   w_gnt;
   logic [NUM_CHANNELS-1:0]                   w_gnt_rd;
   logic [NUM_CONSUMERS-1:0]                  w_claim_scan;
   logic [NUM_CONSUMERS-1:0]                  w_claim_clr;
   logic [NUM_CONSUMERS-1:0]                  w_wr_req;

   // A read-only instance never sees write requests, so no channel can enter the write states.
   assign w_wr_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

   // Next-state and arbitration. w_claim_scan accumulates grants channel by channel so a
   // later channel in the same cycle cannot pick a consumer an earlier channel just took.
   // Released consumers are still marked in r_claimed this cycle, so they are not re-granted
   // until the following cycle.
   always_comb begin
      w_claim_scan = r_claimed;
      w_claim_clr  = '0;
      w_gnt        = '0;
      w_gnt_rd     = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         w_state_nxt[ch] = r_state[ch];
         w_gnt_idx[ch]   = '0;
      end
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         case (r_state[ch])
            IDLE: begin
               for (int c = 0; c < NUM_CONSUMERS; c++) begin
                  if (!w_gnt[ch] && !w_claim_scan[c] &&
                      (consumer_read_valid[c] || w_wr_req[c])) begin
                     w_gnt[ch]       = 1'b1;
                     w_gnt_idx[ch]   = c[CW-1:0];
                     w_gnt_rd[ch]    = consumer_read_valid[c];   // read wins over write
                     w_claim_scan[c] = 1'b1;
                     w_state_nxt[ch] = consumer_read_valid[c] ? READ_WAITING : WRITE_WAITING;
                  end
               end
            end
            READ_WAITING:  if (mem_read_ready[ch])  w_state_nxt[ch] = READ_RELAYING;
            WRITE_WAITING: if (mem_write_ready[ch]) w_state_nxt[ch] = WRITE_RELAYING;
            READ_RELAYING: begin
               if (!consumer_read_valid[r_cur[ch]]) begin
                  w_state_nxt[ch]         = IDLE;
                  w_claim_clr[r_cur[ch]]  = 1'b1;
               end
            end
            WRITE_RELAYING: begin
               if (!consumer_write_valid[r_cur[ch]]) begin
                  w_state_nxt[ch]         = IDLE;
                  w_claim_clr[r_cur[ch]]  = 1'b1;
               end
            end
            default: w_state_nxt[ch] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            r_state[ch] <= IDLE;
            r_cur[ch]   <= '0;
         end
         r_claimed           <= '0;
         r_mem_read_valid    <= '0;
         r_mem_read_address  <= '0;
         r_mem_write_valid   <= '0;
         r_mem_write_address <= '0;
         r_mem_write_data    <= '0;
         r_cons_read_ready   <= '0;
         r_cons_read_data    <= '0;
         r_cons_write_ready  <= '0;
      end else begin
         // Set and clear bits are disjoint: new claims were unclaimed, releases were claimed.
         r_claimed <= (r_claimed & ~w_claim_clr) | (w_claim_scan & ~r_claimed);
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            r_state[ch] <= w_state_nxt[ch];
            case (r_state[ch])
               IDLE: begin
                  if (w_gnt[ch]) begin
                     r_cur[ch] <= w_gnt_idx[ch];
                     if (w_gnt_rd[ch]) begin
                        r_mem_read_valid[ch]   <= 1'b1;
                        r_mem_read_address[ch] <= consumer_read_address[w_gnt_idx[ch]];
                     end else begin
                        r_mem_write_valid[ch]   <= 1'b1;
                        r_mem_write_address[ch] <= consumer_write_address[w_gnt_idx[ch]];
                        r_mem_write_data[ch]    <= consumer_write_data[w_gnt_idx[ch]];
                     end
                  end
               end
               READ_WAITING: begin
                  if (mem_read_ready[ch]) begin
                     r_mem_read_valid[ch]          <= 1'b0;
                     r_cons_read_ready[r_cur[ch]]  <= 1'b1;
                     r_cons_read_data[r_cur[ch]]   <= mem_read_data[ch];
                  end
               end
               WRITE_WAITING: begin
                  if (mem_write_ready[ch]) begin
                     r_mem_write_valid[ch]         <= 1'b0;
                     r_cons_write_ready[r_cur[ch]] <= 1'b1;
                  end
               end
               READ_RELAYING: begin
                  if (!consumer_read_valid[r_cur[ch]]) r_cons_read_ready[r_cur[ch]] <= 1'b0;
               end
               WRITE_RELAYING: begin
                  if (!consumer_write_valid[r_cur[ch]]) r_cons_write_ready[r_cur[ch]] <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign consumer_read_ready  = r_cons_read_ready;
   assign consumer_read_data   = r_cons_read_data;
   assign consumer_write_ready = (WRITE_ENABLE != 0) ? r_cons_write_ready  : '0;
   assign mem_read_valid       = r_mem_read_valid;
   assign mem_read_address     = r_mem_read_address;
   assign mem_write_valid      = (WRITE_ENABLE != 0) ? r_mem_write_valid   : '0;
   assign mem_write_address    = (WRITE_ENABLE != 0) ? r_mem_write_address : '0;
   assign mem_write_data       = (WRITE_ENABLE != 0) ? r_mem_write_data    : '0;

endmodule
